mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port 64-bit memory between the IF stage (32-bit instruction reads)
//  and the MEM stage (64-bit data loads/stores) of the 5-stage pipeline.
//  Arbitrates, sequences each req/ack memory transaction and raises stall_if / stall_mem
//  toward the pipeline registers.
//  Data port has priority; a streak limit guarantees fetch progress.
// PARAMETERS
//  ADDR_W        64   byte-address width of both requester ports
//  MAX_D_STREAK  4    max consecutive data grants while if_req is waiting
//  TIMEOUT       256  BUSY cycles without mem_ack before abort (>=2)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       synchronous reset, active-high
//  if_req     in   1       fetch request; held high until if_valid
//  if_adr     in   ADDR_W  fetch byte address (bits[1:0] ignored)
//  if_rdata   out  32      fetched instruction, valid while if_valid
//  if_valid   out  1       one-cycle fetch completion pulse
//  d_req      in   1       data request; held high until d_valid
//  d_we       in   1       1 = store, 0 = load
//  d_adr      in   ADDR_W  data byte address (bits[2:0] ignored)
//  d_wdata    in   64      store data
//  d_rdata    out  64      load data, valid while d_valid
//  d_valid    out  1       one-cycle data completion pulse (loads and stores)
//  mem_req    out  1       memory transaction active
//  mem_we     out  1       memory write enable
//  mem_adr    out  ADDR_W  64-bit word address = {3'b000, adr[ADDR_W-1:3]}
//  mem_wdata  out  64      memory write data
//  mem_rdata  in   64      memory read data, sampled with mem_ack
//  mem_ack    in   1       one-cycle completion from memory
//  stall_if   out  1       if_req & ~if_valid (combinational)
//  stall_mem  out  1       d_req & ~d_valid (combinational)
//  timeout_err out 1       sticky: a transaction timed out
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0, streak=0, timeout counter=0, timeout_err=0.
//    rst mid-transaction abandons it: mem_req low the next cycle, no valid pulse.
//  - FSM IDLE -> BUSY_IF | BUSY_D -> RESP -> IDLE.
//  - IDLE, edge with requests pending: grant choice is
//      d_req & ~(if_req & streak==MAX_D_STREAK)  -> BUSY_D
//      else if_req                               -> BUSY_IF
//    The granted port's adr/we/wdata are latched at that edge; mem_* are driven only
//    from the latch. mem_req=1 for the whole BUSY state; mem_we=0 for fetch.
//  - streak: +1 on each data grant made while if_req=1; cleared on an IF grant;
//    saturates at MAX_D_STREAK.
//  - BUSY, edge with mem_ack=1: latch mem_rdata, go to RESP.
//    Fetch: if_rdata = adr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
//    Data: d_rdata = mem_rdata (stores return 0).
//  - RESP (1 cycle): granted port's valid=1, mem_req=0. No arbitration in RESP.
//    Requesters drop or replace req during the valid cycle.
//  - Minimum latency: req sampled at E0, mem_req high E0..E1, ack at E1, valid in
//    cycle after E1. Back-to-back transactions: 3 cycles each.
//  - Timeout: counter clears on BUSY entry and counts BUSY cycles.
//    On reaching TIMEOUT without ack: go to RESP with rdata=0, set timeout_err.
//    timeout_err is cleared only by rst.
//  - mem_ack outside BUSY is ignored. Request inputs changing during BUSY are ignored
//    (latched copy used).
//  - Both req in same IDLE cycle with streak<MAX_D_STREAK: data wins; fetch waits;
//    stall_if stays high.
// TESTING
//  1 Reset: rst high 2 cycles with d_req=if_req=1 -> all outputs 0; after rst low,
//    first grant is data.
//  2 Lone fetch: if_adr=0x104, memory acks 1 cycle after mem_req with
//    rdata=0xAAAA_BBBB_1111_2222 -> mem_adr=0x20, if_rdata=0xAAAA_BBBB, one
//    if_valid pulse.
//  3 Store: d_we=1, d_adr=0x18, d_wdata=0xDEAD_BEEF_0000_0001 -> mem_we=1,
//    mem_adr=0x3, wdata matches, d_valid pulses once, stall_mem low next cycle.
//  4 Fairness: d_req and if_req held continuously (MAX_D_STREAK=4) -> grant sequence
//    D,D,D,D,IF,D,D,D,D,IF,...
//  5 Timeout: mem_ack held 0 (TIMEOUT=8) -> mem_req drops after 8 BUSY cycles,
//    valid pulses with rdata=0, timeout_err stays 1 until rst.
//  6 Reset in BUSY_D -> next cycle mem_req=0, d_valid never pulses, state IDLE;
//    late mem_ack ignored.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline requesters, the single-port memory and mem_port_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_adr;
    logic [31:0]       if_rdata;
    logic              if_valid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_adr;
    logic [63:0]       d_wdata;
    logic [63:0]       d_rdata;
    logic              d_valid;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_adr;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;
    logic              mem_ack;
    logic              stall_if;
    logic              stall_mem;
    logic              timeout_err;

    modport slave (
        input  if_req, if_adr, d_req, d_we, d_adr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_valid, d_rdata, d_valid, mem_req, mem_we, mem_adr, mem_wdata,
               stall_if, stall_mem, timeout_err
    );

    modport master (
        output if_req, if_adr, d_req, d_we, d_adr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_valid, d_rdata, d_valid, mem_req, mem_we, mem_adr, mem_wdata,
               stall_if, stall_mem, timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port 64-bit memory between instruction fetch and data access.
// Data has priority; a bounded data-grant streak guarantees fetch progress.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 256
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam int unsigned TMO_W    = $clog2(TIMEOUT);
    localparam int unsigned WADR_W   = ADDR_W - 3;

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

    state_t              state_q, state_d;
    logic                grant_d, grant_if, finish, timed_out;
    logic [WADR_W-1:0]   wadr_q;
    logic                half_q, we_q, own_d_q;
    logic [63:0]         wdata_q, rdata_q;
    logic [STREAK_W-1:0] streak_q;
    logic [TMO_W-1:0]    tmo_q;
    logic                timeout_err_q;
    logic                busy, if_vld, d_vld, streak_full;
    logic                unused_adr_bits;

    assign busy        = (state_q == BUSY_IF) || (state_q == BUSY_D);
    assign streak_full = (streak_q == STREAK_W'(MAX_D_STREAK));

    // Next state: arbitration only in IDLE, completion by ack or timeout in BUSY.
    always_comb begin
        state_d   = state_q;
        grant_d   = 1'b0;
        grant_if  = 1'b0;
        finish    = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.d_req && !(bus.if_req && streak_full)) begin
                    grant_d = 1'b1;
                    state_d = BUSY_D;
                end else if (bus.if_req) begin
                    grant_if = 1'b1;
                    state_d  = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (bus.mem_ack) begin
                    finish  = 1'b1;
                    state_d = RESP;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wadr_q        <= '0;
            half_q        <= 1'b0;
            we_q          <= 1'b0;
            own_d_q       <= 1'b0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            streak_q      <= '0;
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Latch the granted request; the memory side only ever sees this copy.
            if (grant_d || grant_if) begin
                wadr_q  <= grant_d ? bus.d_adr[ADDR_W-1:3] : bus.if_adr[ADDR_W-1:3];
                half_q  <= grant_if & bus.if_adr[2];
                we_q    <= grant_d & bus.d_we;
                wdata_q <= grant_d ? bus.d_wdata : '0;
                own_d_q <= grant_d;
                tmo_q   <= '0;
            end else if (busy) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
            if (grant_if) begin
                streak_q <= '0;
            end else if (grant_d && bus.if_req && !streak_full) begin
                streak_q <= streak_q + STREAK_W'(1);
            end
            if (finish) begin
                if (timed_out || we_q) begin
                    rdata_q <= '0;
                end else if (own_d_q) begin
                    rdata_q <= bus.mem_rdata;
                end else begin
                    rdata_q <= {32'h0, half_q ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0]};
                end
            end
            if (timed_out) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign if_vld = (state_q == RESP) && !own_d_q;
    assign d_vld  = (state_q == RESP) && own_d_q;

    assign bus.if_valid    = if_vld;
    assign bus.d_valid     = d_vld;
    assign bus.if_rdata    = if_vld ? rdata_q[31:0] : 32'h0;
    assign bus.d_rdata     = d_vld ? rdata_q : 64'h0;
    assign bus.mem_req     = busy;
    assign bus.mem_we      = busy & we_q;
    assign bus.mem_adr     = busy ? {3'b000, wadr_q} : '0;
    assign bus.mem_wdata   = busy ? wdata_q : 64'h0;
    assign bus.stall_if    = !rst && bus.if_req && !if_vld;
    assign bus.stall_mem   = !rst && bus.d_req && !d_vld;
    assign bus.timeout_err = timeout_err_q;

    // Address bits below the access granularity carry no information.
    assign unused_adr_bits = ^{bus.if_adr[1:0], bus.d_adr[2:0]};
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int unsigned MAXS = 4;
    localparam int unsigned TMO  = 8;

    logic        clk;
    logic        rst, if_req, d_req, d_we, mem_ack;
    logic [63:0] if_adr, d_adr, d_wdata, mem_rdata;

    mem_port_arbiter_if #(.ADDR_W(64)) bus ();

    assign bus.if_req    = if_req;
    assign bus.if_adr    = if_adr;
    assign bus.d_req     = d_req;
    assign bus.d_we      = d_we;
    assign bus.d_adr     = d_adr;
    assign bus.d_wdata   = d_wdata;
    assign bus.mem_rdata = mem_rdata;
    assign bus.mem_ack   = mem_ack;

    mem_port_arbiter #(.ADDR_W(64), .MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_vec = 0;
    int  n_err = 0;
    bit  check_en = 1'b0;

    // Reference model: 0 = no transaction, 1 = memory access in flight, 2 = response cycle.
    int          mode = 0;
    bit          m_own_d, m_we, m_terr;
    logic [63:0] m_adr, m_wdata, m_resp;
    int          m_busy, m_streak;

    int          ack_mode;
    logic [63:0] fixed_rdata;
    bit          exp_if_v, exp_d_v;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic model_step();
        if (rst) begin
            mode = 0; m_streak = 0; m_terr = 0; m_busy = 0;
        end else begin
            case (mode)
                0: begin
                    if (d_req && !(if_req && m_streak == MAXS)) begin
                        mode = 1; m_own_d = 1; m_adr = d_adr; m_we = d_we; m_wdata = d_wdata; m_busy = 0;
                        if (if_req && m_streak < MAXS) m_streak++;
                    end else if (if_req) begin
                        mode = 1; m_own_d = 0; m_adr = if_adr; m_we = 0; m_wdata = 0; m_busy = 0;
                        m_streak = 0;
                    end
                end
                1: begin
                    m_busy++;
                    if (mem_ack) begin
                        mode = 2;
                        if (!m_own_d) m_resp = m_adr[2] ? {32'h0, mem_rdata[63:32]} : {32'h0, mem_rdata[31:0]};
                        else          m_resp = m_we ? 64'h0 : mem_rdata;
                    end else if (m_busy == TMO) begin
                        mode = 2; m_resp = 64'h0; m_terr = 1;
                    end
                end
                default: mode = 0;
            endcase
        end
    endtask

    // Memory responder: 0 = ack on first access cycle, 1 = random, 2 = never, 3 = manual.
    task automatic drive_mem();
        case (ack_mode)
            0: begin mem_ack = (mode == 1); mem_rdata = fixed_rdata; end
            1: begin mem_ack = ($urandom_range(0, 2) == 0); mem_rdata = {$urandom, $urandom}; end
            2: mem_ack = 1'b0;
            default: ;
        endcase
    endtask

    task automatic next();
        @(posedge clk);
        model_step();
        #1;
        drive_mem();
    endtask

    task automatic serve(input int n);
        for (int i = 0; i < n; i++) begin
            next();
            if (mode == 2) begin
                if (m_own_d) d_req = 1'b0;
                else         if_req = 1'b0;
            end
        end
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            exp_if_v = (mode == 2) && !m_own_d;
            exp_d_v  = (mode == 2) && m_own_d;
            chk("mem_req", 64'(bus.mem_req), 64'(mode == 1));
            if (mode == 1) begin
                chk("mem_adr", bus.mem_adr, m_adr >> 3);
                chk("mem_we", 64'(bus.mem_we), 64'(m_own_d && m_we));
                if (m_own_d && m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
            end
            chk("if_valid", 64'(bus.if_valid), 64'(exp_if_v));
            chk("d_valid", 64'(bus.d_valid), 64'(exp_d_v));
            if (exp_if_v) chk("if_rdata", 64'(bus.if_rdata), m_resp);
            if (exp_d_v)  chk("d_rdata", bus.d_rdata, m_resp);
            chk("stall_if", 64'(bus.stall_if), 64'(!rst && if_req && !exp_if_v));
            chk("stall_mem", 64'(bus.stall_mem), 64'(!rst && d_req && !exp_d_v));
            chk("timeout_err", 64'(bus.timeout_err), 64'(m_terr));
        end
    end

    initial begin
        string exp_seq;
        byte   got[$];
        bit    prev, seen, dv;
        int    cnt;

        // Reset with both requests pending.
        rst = 1; if_req = 1; d_req = 1; d_we = 0; mem_ack = 0;
        if_adr = 64'h80; d_adr = 64'h40; d_wdata = 0; mem_rdata = 0;
        ack_mode = 0; fixed_rdata = 64'h1234_5678_9ABC_DEF0;
        next();
        check_en = 1'b1;
        next();
        chk("rst_mem_req", 64'(bus.mem_req), 64'h0);
        chk("rst_valids", 64'({bus.if_valid, bus.d_valid}), 64'h0);
        chk("rst_stalls", 64'({bus.stall_if, bus.stall_mem}), 64'h0);
        chk("rst_terr", 64'(bus.timeout_err), 64'h0);
        rst = 0;
        next();
        chk("first_grant_req", 64'(bus.mem_req), 64'h1);
        chk("first_grant_is_data", bus.mem_adr, 64'h8);
        serve(12);
        chk("drain1", 64'({bus.stall_if, bus.stall_mem, bus.mem_req}), 64'h0);

        // Lone fetch from the upper half of a word.
        if_req = 1; if_adr = 64'h104; fixed_rdata = 64'hAAAA_BBBB_1111_2222;
        next();
        chk("fetch_mem_adr", bus.mem_adr, 64'h20);
        chk("fetch_mem_we", 64'(bus.mem_we), 64'h0);
        next();
        chk("fetch_valid", 64'(bus.if_valid), 64'h1);
        chk("fetch_rdata", 64'(bus.if_rdata), 64'hAAAA_BBBB);
        if_req = 0;
        next();
        chk("fetch_single_pulse", 64'(bus.if_valid), 64'h0);

        // Store.
        d_req = 1; d_we = 1; d_adr = 64'h18; d_wdata = 64'hDEAD_BEEF_0000_0001;
        next();
        chk("store_mem_we", 64'(bus.mem_we), 64'h1);
        chk("store_mem_adr", bus.mem_adr, 64'h3);
        chk("store_mem_wdata", bus.mem_wdata, 64'hDEAD_BEEF_0000_0001);
        next();
        chk("store_valid", 64'(bus.d_valid), 64'h1);
        d_req = 0; d_we = 0;
        #1;
        chk("store_stall_mem", 64'(bus.stall_mem), 64'h0);
        next();
        chk("store_single_pulse", 64'(bus.d_valid), 64'h0);
        chk("store_stall_after", 64'(bus.stall_mem), 64'h0);

        // Fairness with both requests held.
        d_adr = 64'h1000; if_adr = 64'h2000; d_req = 1; if_req = 1;
        exp_seq = "DDDDIDDDDI";
        prev = bus.mem_req;
        for (int c = 0; c < 60 && got.size() < 10; c++) begin
            next();
            if (bus.mem_req && !prev) got.push_back(bus.mem_adr == 64'h200 ? 8'd68 : 8'd73);
            prev = bus.mem_req;
        end
        for (int i = 0; i < 10; i++)
            chk($sformatf("grant_seq[%0d]", i), 64'(i < got.size() ? got[i] : 8'd0), 64'(exp_seq[i]));
        serve(30);
        chk("drain4", 64'({bus.stall_if, bus.stall_mem, bus.mem_req}), 64'h0);

        // Timeout: memory never answers.
        ack_mode = 2; d_req = 1; d_adr = 64'h50; cnt = 0; seen = 0;
        for (int c = 0; c < 30; c++) begin
            next();
            if (bus.mem_req) cnt++;
            if (bus.d_valid) begin
                seen = 1;
                chk("tmo_rdata", bus.d_rdata, 64'h0);
                break;
            end
        end
        chk("tmo_busy_cycles", 64'(cnt), 64'(TMO));
        chk("tmo_valid_seen", 64'(seen), 64'h1);
        chk("tmo_err_set", 64'(bus.timeout_err), 64'h1);
        d_req = 0;
        repeat (3) next();
        chk("tmo_err_sticky", 64'(bus.timeout_err), 64'h1);

        // Reset in the middle of a data access, then a late ack.
        d_req = 1; d_adr = 64'h60;
        next();
        chk("rstbusy_req_before", 64'(bus.mem_req), 64'h1);
        rst = 1;
        next();
        chk("rstbusy_mem_req", 64'(bus.mem_req), 64'h0);
        chk("rstbusy_terr_clr", 64'(bus.timeout_err), 64'h0);
        rst = 0; d_req = 0; ack_mode = 3; mem_ack = 1; dv = 0;
        repeat (3) begin
            next();
            if (bus.d_valid) dv = 1;
        end
        chk("late_ack_no_valid", 64'(dv), 64'h0);
        chk("late_ack_no_req", 64'(bus.mem_req), 64'h0);
        mem_ack = 0;

        // Randomized traffic with occasional resets and timeouts.
        ack_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            next();
            if (mode == 2) begin
                if (m_own_d) d_req = 1'b0;
                else         if_req = 1'b0;
            end
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_adr = {$urandom, $urandom};
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1));
                d_adr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
            end
            if (mode == 1 && $urandom_range(0, 3) == 0) begin
                if_adr = {$urandom, $urandom}; d_adr = {$urandom, $urandom};
                d_wdata = {$urandom, $urandom}; d_we = 1'($urandom_range(0, 1));
            end
            rst = ($urandom_range(0, 199) == 0);
        end
        rst = 0;
        next();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
